// File: rtl/axi_xbar_pkg.sv
// Shared crossbar types: the R-channel response code and the stored beat word.
package axi_xbar_pkg;

    localparam int ID_W   = 4;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } resp_t;

    // One R beat as held in buffer storage, written as a single word.
    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        resp_t             resp;
        logic              last;
    } r_beat_t;

endpackage

// File: rtl/r_burst_fifo_if.sv
// AXI R channel bundle.
// Handshake: a beat transfers on a rising ACLK edge where RVALID and RREADY
// are both high. Once RVALID is high the source holds it and the payload
// (RID/RDATA/RRESP/RLAST) stable until that transfer; RVALID never waits on
// RREADY.
interface r_burst_fifo_if #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32
) ();

    logic [ID_WIDTH-1:0]   RID;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;

    modport master (output RID, RDATA, RRESP, RLAST, RVALID, input RREADY);
    modport slave  (input RID, RDATA, RRESP, RLAST, RVALID, output RREADY);

endinterface

// File: rtl/r_burst_fifo_ring_ptr.sv
// Ring index for a DEPTH-entry buffer; wraps DEPTH-1 -> 0 for any DEPTH >= 2.
module ring_ptr #(
    parameter int DEPTH = 8
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic                     inc,
    output logic [$clog2(DEPTH)-1:0] ptr
);

    localparam int PW = $clog2(DEPTH);

    // Advance on inc, wrapping explicitly at the last entry.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/r_burst_fifo.sv
// R-channel buffer between a slave R port and the crossbar R arbiter.
// Optional packet mode presents data only once a whole burst is stored,
// or when the buffer is full so over-long bursts cannot deadlock.
module r_burst_fifo
    import axi_xbar_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int ID_WIDTH    = ID_W,
    parameter int DATA_WIDTH  = DATA_W,
    parameter int PACKET_MODE = 0,
    parameter int AFULL_LEVEL = DEPTH - 2
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    r_burst_fifo_if.slave              s,
    r_burst_fifo_if.master             m,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [$clog2(DEPTH+1)-1:0] bursts,
    output logic                       almost_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    r_beat_t               mem [DEPTH];
    r_beat_t               wr_beat;
    r_beat_t               head;
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [ID_WIDTH-1:0]   s_id;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  push_last;
    logic                  pop_last;

    assign s_id   = s.RID;
    assign s_data = s.RDATA;

    assign wr_beat.id   = s_id;
    assign wr_beat.data = s_data;
    assign wr_beat.resp = resp_t'(s.RRESP);
    assign wr_beat.last = s.RLAST;

    assign head = mem[rptr];
    assign full = (count == CW'(DEPTH));

    // Ready comes from registered occupancy only; reset gates it low.
    assign s.RREADY = ARESETn & ~full;
    assign m.RVALID = (PACKET_MODE != 0) ? ((bursts != '0) | full) : (count != '0);

    assign m.RID   = head.id;
    assign m.RDATA = head.data;
    assign m.RRESP = head.resp;
    assign m.RLAST = head.last;

    assign push      = s.RVALID & s.RREADY;
    assign pop       = m.RVALID & m.RREADY;
    assign push_last = push & s.RLAST;
    assign pop_last  = pop & head.last;

    assign almost_full = (int'(count) >= AFULL_LEVEL);

    ring_ptr #(.DEPTH(DEPTH)) u_wptr (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .inc     (push),
        .ptr     (wptr)
    );

    ring_ptr #(.DEPTH(DEPTH)) u_rptr (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .inc     (pop),
        .ptr     (rptr)
    );

    // Storage: cleared on reset so the head reads zero, one word per push.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wptr] <= wr_beat;
        end
    end

    // Occupancy and stored-burst counters; simultaneous inc/dec cancel.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            count  <= '0;
            bursts <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            case ({push_last, pop_last})
                2'b10:   bursts <= bursts + CW'(1);
                2'b01:   bursts <= bursts - CW'(1);
                default: bursts <= bursts;
            endcase
        end
    end

endmodule

// File: tb/tb_r_burst_fifo.sv
// Bench for r_burst_fifo: three instances (DEPTH=5 normal, DEPTH=8 packet,
// DEPTH=4 packet), directed stimulus, queue-based scoreboards per instance.
module tb_r_burst_fifo;

    localparam int BW = 4 + 32 + 2 + 1;

    logic ACLK;
    logic rstn;

    logic [2:0] count_a, bursts_a;
    logic [3:0] count_b, bursts_b;
    logic [2:0] count_c, bursts_c;
    logic       afull_a, afull_b, afull_c;

    r_burst_fifo_if #(.ID_WIDTH(4), .DATA_WIDTH(32)) sa ();
    r_burst_fifo_if #(.ID_WIDTH(4), .DATA_WIDTH(32)) ma ();
    r_burst_fifo_if #(.ID_WIDTH(4), .DATA_WIDTH(32)) sb ();
    r_burst_fifo_if #(.ID_WIDTH(4), .DATA_WIDTH(32)) mb ();
    r_burst_fifo_if #(.ID_WIDTH(4), .DATA_WIDTH(32)) sc ();
    r_burst_fifo_if #(.ID_WIDTH(4), .DATA_WIDTH(32)) mc ();

    r_burst_fifo #(.DEPTH(5), .PACKET_MODE(0)) dut_a (
        .ACLK(ACLK), .ARESETn(rstn), .s(sa), .m(ma),
        .count(count_a), .bursts(bursts_a), .almost_full(afull_a)
    );
    r_burst_fifo #(.DEPTH(8), .PACKET_MODE(1)) dut_b (
        .ACLK(ACLK), .ARESETn(rstn), .s(sb), .m(mb),
        .count(count_b), .bursts(bursts_b), .almost_full(afull_b)
    );
    r_burst_fifo #(.DEPTH(4), .PACKET_MODE(1)) dut_c (
        .ACLK(ACLK), .ARESETn(rstn), .s(sc), .m(mc),
        .count(count_c), .bursts(bursts_c), .almost_full(afull_c)
    );

    logic [BW-1:0] exp_a[$];
    logic [BW-1:0] exp_b[$];
    logic [BW-1:0] exp_c[$];

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- clock / reset ----------------
    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [BW-1:0] mk(input logic [3:0] id, input logic [31:0] data,
                                         input logic [1:0] resp, input logic last);
        return {id, data, resp, last};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, got, expv);
        end
    endtask

    function automatic logic rdy(input int sel);
        case (sel)
            0:       return sa.RREADY;
            1:       return sb.RREADY;
            default: return sc.RREADY;
        endcase
    endfunction

    function automatic int cnt(input int sel);
        case (sel)
            0:       return int'(count_a);
            1:       return int'(count_b);
            default: return int'(count_c);
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input int sel, input logic v, input logic [BW-1:0] b);
        case (sel)
            0: begin sa.RVALID = v; {sa.RID, sa.RDATA, sa.RRESP, sa.RLAST} = b; end
            1: begin sb.RVALID = v; {sb.RID, sb.RDATA, sb.RRESP, sb.RLAST} = b; end
            default: begin sc.RVALID = v; {sc.RID, sc.RDATA, sc.RRESP, sc.RLAST} = b; end
        endcase
    endtask

    // Presents one beat and returns #1 after the edge that accepted it;
    // RVALID is left high so the next call streams back-to-back.
    task automatic send(input int sel, input logic [BW-1:0] b);
        int  waited;
        bit  done;
        waited = 0;
        done   = 0;
        drive(sel, 1'b1, b);
        while (!done) begin
            @(negedge ACLK);
            if (rdy(sel)) begin
                case (sel)
                    0:       exp_a.push_back(b);
                    1:       exp_b.push_back(b);
                    default: exp_c.push_back(b);
                endcase
                done = 1;
            end else if (waited >= 200) begin
                n_cmp++;
                n_err++;
                $display("FAIL send_timeout sel=%0d: got no s_RREADY required acceptance", sel);
                done = 1;
            end
            waited++;
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic drain(input int sel, input string name);
        int waited;
        waited = 0;
        while (cnt(sel) != 0 && waited < 100) begin
            @(posedge ACLK);
            #1;
            waited++;
        end
        chk(name, 64'(cnt(sel)), 64'd0);
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge ACLK) begin : mon_a
        logic [BW-1:0] got, e;
        if (rstn && ma.RVALID && ma.RREADY) begin
            got = {ma.RID, ma.RDATA, ma.RRESP, ma.RLAST};
            if (exp_a.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL mon_a: got unexpected beat %h required none", got);
            end else begin
                e = exp_a.pop_front();
                chk("mon_a beat", 64'(got), 64'(e));
            end
        end
    end

    always @(negedge ACLK) begin : mon_b
        logic [BW-1:0] got, e;
        if (rstn && mb.RVALID && mb.RREADY) begin
            got = {mb.RID, mb.RDATA, mb.RRESP, mb.RLAST};
            if (exp_b.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL mon_b: got unexpected beat %h required none", got);
            end else begin
                e = exp_b.pop_front();
                chk("mon_b beat", 64'(got), 64'(e));
            end
        end
    end

    always @(negedge ACLK) begin : mon_c
        logic [BW-1:0] got, e;
        if (rstn && mc.RVALID && mc.RREADY) begin
            got = {mc.RID, mc.RDATA, mc.RRESP, mc.RLAST};
            if (exp_c.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL mon_c: got unexpected beat %h required none", got);
            end else begin
                e = exp_c.pop_front();
                chk("mon_c beat", 64'(got), 64'(e));
            end
        end
    end

    // Occupancy model and payload stability for the DEPTH=5 instance.
    int            mcnt_a = 0;
    bit            stall_prev = 0;
    logic [BW-1:0] held;
    always @(negedge ACLK) begin : model_a
        logic [BW-1:0] cur;
        cur = {ma.RID, ma.RDATA, ma.RRESP, ma.RLAST};
        if (!rstn) begin
            mcnt_a     = 0;
            stall_prev = 0;
        end else begin
            chk("a_count_model", 64'(count_a), 64'(mcnt_a));
            chk("a_s_rready_model", 64'(sa.RREADY), 64'(mcnt_a != 5));
            chk("a_m_rvalid_model", 64'(ma.RVALID), 64'(mcnt_a != 0));
            if (stall_prev) begin
                chk("a_stall_valid", 64'(ma.RVALID), 64'd1);
                chk("a_stall_payload", 64'(cur), 64'(held));
            end
            mcnt_a = mcnt_a + ((sa.RVALID && sa.RREADY) ? 1 : 0)
                            - ((ma.RVALID && ma.RREADY) ? 1 : 0);
            stall_prev = ma.RVALID && !ma.RREADY;
            held       = cur;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        rstn = 1'b0;
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        drive(2, 1'b0, '0);
        ma.RREADY = 1'b0;
        mb.RREADY = 1'b0;
        mc.RREADY = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;

        // Reset state
        chk("rst_count", 64'(count_a), 64'd0);
        chk("rst_bursts", 64'(bursts_a), 64'd0);
        chk("rst_m_rvalid", 64'(ma.RVALID), 64'd0);
        chk("rst_m_rdata", 64'(ma.RDATA), 64'd0);
        chk("rst_s_rready_low", 64'(sa.RREADY), 64'd0);
        chk("rst_almost_full", 64'(afull_a), 64'd0);
        rstn = 1'b1;
        #1;
        chk("rst_s_rready_high", 64'(sa.RREADY), 64'd1);
        @(posedge ACLK);
        #1;

        // Fill DEPTH=5 with m_RREADY low
        for (int i = 1; i <= 5; i++) begin
            send(0, mk(4'(i), 32'(i), 2'd0, i == 5));
            chk("fill_count", 64'(count_a), 64'(i));
            chk("fill_almost_full", 64'(afull_a), 64'(i >= 3));
        end
        chk("full_s_rready", 64'(sa.RREADY), 64'd0);
        chk("full_bursts", 64'(bursts_a), 64'd1);
        // 6th beat must be refused
        drive(0, 1'b1, mk(4'd6, 32'd6, 2'd0, 1'b0));
        repeat (3) begin
            @(negedge ACLK);
            chk("sixth_refused", 64'(sa.RREADY), 64'd0);
            @(posedge ACLK);
            #1;
        end
        drive(0, 1'b0, '0);
        chk("sixth_count", 64'(count_a), 64'd5);
        ma.RREADY = 1'b1;
        drain(0, "drain_5");
        chk("drain_5_rvalid", 64'(ma.RVALID), 64'd0);
        chk("drain_5_bursts", 64'(bursts_a), 64'd0);

        // Wrap-around: concurrent push/pop, count holds at 1
        for (int i = 0; i < 12; i++) begin
            send(0, mk(4'(i), 32'h100 + 32'(i), 2'(i % 4), (i % 4) == 3));
            chk("wrap_count", 64'(count_a), 64'd1);
        end
        drive(0, 1'b0, '0);
        drain(0, "wrap_drain");

        // Backpressure: random m_RREADY against a continuous source
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    send(0, mk(4'(i), 32'h200 + 32'(i), 2'd1, (i % 5) == 4));
                end
                drive(0, 1'b0, '0);
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    ma.RREADY = 1'($urandom_range(0, 1));
                    @(posedge ACLK);
                    #1;
                end
                ma.RREADY = 1'b1;
            end
        join
        drain(0, "bp_drain");
        ma.RREADY = 1'b0;

        // Packet mode DEPTH=8: 3-beat burst with m_RREADY high
        mb.RREADY = 1'b1;
        send(1, mk(4'd3, 32'hB1, 2'd0, 1'b0));
        chk("pkt_b_valid1", 64'(mb.RVALID), 64'd0);
        send(1, mk(4'd3, 32'hB2, 2'd0, 1'b0));
        chk("pkt_b_valid2", 64'(mb.RVALID), 64'd0);
        send(1, mk(4'd3, 32'hB3, 2'd2, 1'b1));
        drive(1, 1'b0, '0);
        chk("pkt_b_valid3", 64'(mb.RVALID), 64'd1);
        chk("pkt_b_bursts1", 64'(bursts_b), 64'd1);
        drain(1, "pkt_b_drain");
        chk("pkt_b_bursts0", 64'(bursts_b), 64'd0);

        // Packet mode DEPTH=4: 6-beat burst longer than the buffer
        for (int i = 1; i <= 4; i++) begin
            send(2, mk(4'd5, 32'hC0 + 32'(i), 2'd0, 1'b0));
            if (i < 4) chk("long_c_valid_low", 64'(mc.RVALID), 64'd0);
        end
        chk("long_c_valid_full", 64'(mc.RVALID), 64'd1);
        chk("long_c_count", 64'(count_c), 64'd4);
        chk("long_c_bursts", 64'(bursts_c), 64'd0);
        mc.RREADY = 1'b1;
        send(2, mk(4'd5, 32'hC5, 2'd0, 1'b0));
        send(2, mk(4'd5, 32'hC6, 2'd3, 1'b1));
        drive(2, 1'b0, '0);
        drain(2, "long_c_drain");
        chk("long_c_bursts_end", 64'(bursts_c), 64'd0);

        // Reset mid-operation on DEPTH=5 with three beats stored
        ma.RREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(0, mk(4'hA, 32'hDEAD0 + 32'(i), 2'd1, 1'b1));
        end
        drive(0, 1'b0, '0);
        chk("mid_count3", 64'(count_a), 64'd3);
        rstn = 1'b0;
        exp_a.delete();
        @(posedge ACLK);
        #1;
        chk("mid_rst_count", 64'(count_a), 64'd0);
        chk("mid_rst_bursts", 64'(bursts_a), 64'd0);
        chk("mid_rst_rvalid", 64'(ma.RVALID), 64'd0);
        chk("mid_rst_rdata", 64'(ma.RDATA), 64'd0);
        chk("mid_rst_s_rready", 64'(sa.RREADY), 64'd0);
        rstn = 1'b1;
        #1;
        chk("mid_rst_s_rready_up", 64'(sa.RREADY), 64'd1);
        repeat (2) @(posedge ACLK);
        #1;

        // All expected beats consumed
        chk("exp_a_empty", 64'(exp_a.size()), 64'd0);
        chk("exp_b_empty", 64'(exp_b.size()), 64'd0);
        chk("exp_c_empty", 64'(exp_c.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
